// File: rtl/dm_port_arbiter_if.sv
// dm_port_arbiter_if
//   Bundles every signal that passes between the M stage, the external
//   word-burst requester, the data memory and the arbiter.
//   modport slave  : the arbiter's view (requests and DM_RD in, grants and DM
//                    controls out).
//   modport master : the environment's view (the M stage, the external
//                    requester and the data memory together).
//   Signal groups:
//     M_*  : pipeline M-stage request, store data and returned read data.
//     X_*  : external burst request, beat/read/status feedback.
//     DM_* : data memory write enable, address, write data, op and read data.
interface dm_port_arbiter_if;
   logic        M_Req;
   logic        M_Wr;
   logic [31:0] M_Addr;
   logic [31:0] M_WD;
   logic [2:0]  M_Op;
   logic        M_Stall;
   logic [31:0] M_RD;

   logic        X_Req;
   logic        X_Wr;
   logic [31:0] X_Addr;
   logic [2:0]  X_Len;
   logic [31:0] X_WD;
   logic        X_Beat;
   logic [31:0] X_RD;
   logic        X_RValid;
   logic        X_Busy;
   logic        X_Done;

   logic        DM_Wr;
   logic [31:0] DM_A;
   logic [31:0] DM_WD;
   logic [2:0]  DM_Op;
   logic [31:0] DM_RD;

   modport slave (
      input  M_Req, M_Wr, M_Addr, M_WD, M_Op,
      output M_Stall, M_RD,
      input  X_Req, X_Wr, X_Addr, X_Len, X_WD,
      output X_Beat, X_RD, X_RValid, X_Busy, X_Done,
      output DM_Wr, DM_A, DM_WD, DM_Op,
      input  DM_RD
   );

   modport master (
      output M_Req, M_Wr, M_Addr, M_WD, M_Op,
      input  M_Stall, M_RD,
      output X_Req, X_Wr, X_Addr, X_Len, X_WD,
      input  X_Beat, X_RD, X_RValid, X_Busy, X_Done,
      input  DM_Wr, DM_A, DM_WD, DM_Op,
      output DM_RD
   );
endinterface

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
//   Shares the single data memory between the pipeline M stage and one
//   external word-burst requester (debug/DMA). The pipeline wins every
//   contested cycle, but after MAX_WAIT consecutive denied cycles the
//   external side gets one forced beat and the M stage stalls for that cycle.
//   Ports:
//     Clk  : clock, rising edge.
//     Rst  : asynchronous, active-low reset.
//     bus  : dm_port_arbiter_if.slave carrying the M-stage, external-port and
//            data-memory signals.
//   Parameters:
//     MAX_WAIT : denied cycles before a forced external beat (1..15).
//     WORD_OP  : DM op code driven for external word accesses.
module dm_port_arbiter #(
   parameter int          MAX_WAIT = 4,
   parameter logic [2:0]  WORD_OP  = 3'd0
) (
   input  logic               Clk,
   input  logic               Rst,
   dm_port_arbiter_if.slave   bus
);

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      FORCE = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] addr_q;
   logic [2:0]  beats_left;
   logic        wr_q;
   logic [3:0]  wait_cnt;
   logic [31:0] x_rd_q;
   logic        x_rvalid_q;
   logic        x_done_q;

   logic        ext_gnt;
   logic [3:0]  wait_inc;

   // The external side owns the DM whenever the pipeline is idle during a
   // burst, or unconditionally while a forced beat is due.
   assign ext_gnt  = ((state == BURST) && !bus.M_Req) || (state == FORCE);
   assign wait_inc = wait_cnt + 4'd1;

   // Grant, stall and status outputs
   assign bus.M_Stall  = bus.M_Req && (state == FORCE);
   assign bus.X_Beat   = ext_gnt;
   assign bus.X_Busy   = (state != IDLE);
   assign bus.X_RD     = x_rd_q;
   assign bus.X_RValid = x_rvalid_q;
   assign bus.X_Done   = x_done_q;
   assign bus.M_RD     = bus.DM_RD;

   // DM mux: X_Req never reaches these outputs; only registered burst state
   // and the M-stage inputs do.
   always_comb begin
      bus.DM_Wr = bus.M_Req && bus.M_Wr;
      bus.DM_A  = bus.M_Addr;
      bus.DM_WD = bus.M_WD;
      bus.DM_Op = bus.M_Op;
      if (ext_gnt) begin
         bus.DM_Wr = wr_q;
         bus.DM_A  = addr_q;
         bus.DM_WD = bus.X_WD;
         bus.DM_Op = WORD_OP;
      end
   end

   // Burst FSM and registered external-port outputs
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state      <= IDLE;
         addr_q     <= 32'd0;
         beats_left <= 3'd0;
         wr_q       <= 1'b0;
         wait_cnt   <= 4'd0;
         x_rd_q     <= 32'd0;
         x_rvalid_q <= 1'b0;
         x_done_q   <= 1'b0;
      end else begin
         x_rvalid_q <= 1'b0;
         x_done_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.X_Req) begin
                  // Low address bits are ignored: bursts are word aligned.
                  addr_q     <= bus.X_Addr & 32'hFFFF_FFFC;
                  beats_left <= bus.X_Len;
                  wr_q       <= bus.X_Wr;
                  wait_cnt   <= 4'd0;
                  state      <= BURST;
               end
            end
            BURST, FORCE: begin
               if (ext_gnt) begin
                  addr_q     <= addr_q + 32'd4;
                  beats_left <= beats_left - 3'd1;
                  wait_cnt   <= 4'd0;
                  if (!wr_q) begin
                     x_rd_q     <= bus.DM_RD;
                     x_rvalid_q <= 1'b1;
                  end
                  if (beats_left == 3'd0) begin
                     state    <= IDLE;
                     x_done_q <= 1'b1;
                  end else begin
                     state <= BURST;
                  end
               end else begin
                  // Only reachable in BURST with the pipeline holding the DM.
                  wait_cnt <= wait_inc;
                  if (wait_inc == MAX_WAIT_C) begin
                     state <= FORCE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;

   localparam int         MW  = 4;
   localparam logic [2:0] WOP = 3'd5;

   logic Clk = 1'b0;
   logic Rst;
   always #5 Clk = ~Clk;

   dm_port_arbiter_if ifc ();

   dm_port_arbiter #(.MAX_WAIT(MW), .WORD_OP(WOP)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (ifc.slave)
   );

   // Data memory stand-in: read data is a fixed scramble of the address.
   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction
   assign ifc.DM_RD = mem_val(ifc.DM_A);

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: the outstanding burst is just a queue of word
   // addresses still to be transferred plus a count of denied cycles.
   logic [31:0] beat_q[$];
   logic        m_wr;
   int          starve;
   logic        e_done, e_rv;
   logic [31:0] e_rd;
   int          obs_beats, obs_stalls;

   task automatic model_reset();
      beat_q.delete();
      m_wr   = 1'b0;
      starve = 0;
      e_done = 1'b0;
      e_rv   = 1'b0;
      e_rd   = 32'd0;
   endtask

   // One clock cycle: drive inputs, check outputs at the falling edge,
   // advance the model at the rising edge.
   task automatic cyc(input logic req, input logic wr, input logic xreq, input logic xwr,
                      input logic [31:0] xaddr, input logic [2:0] xlen);
      logic        busy, forced, gnt;
      logic [31:0] a;
      ifc.M_Req  = req;
      ifc.M_Wr   = wr;
      ifc.M_Addr = $urandom;
      ifc.M_WD   = $urandom;
      ifc.M_Op   = 3'($urandom_range(0, 7));
      ifc.X_Req  = xreq;
      ifc.X_Wr   = xwr;
      ifc.X_Addr = xaddr;
      ifc.X_Len  = xlen;
      ifc.X_WD   = $urandom;
      busy   = (beat_q.size() != 0) && Rst;
      forced = busy && (starve == MW);
      gnt    = busy && (forced || !req);
      @(negedge Clk);
      if (ifc.X_Beat === 1'b1)  obs_beats++;
      if (ifc.M_Stall === 1'b1) obs_stalls++;
      check("m_stall",  32'(ifc.M_Stall),  32'(req && forced));
      check("x_beat",   32'(ifc.X_Beat),   32'(gnt));
      check("x_busy",   32'(ifc.X_Busy),   32'(busy));
      check("x_done",   32'(ifc.X_Done),   32'(e_done));
      check("x_rvalid", 32'(ifc.X_RValid), 32'(e_rv));
      check("x_rd",     ifc.X_RD,          e_rd);
      check("dm_wr",    32'(ifc.DM_Wr),    gnt ? 32'(m_wr) : 32'(req && wr));
      check("dm_a",     ifc.DM_A,          gnt ? beat_q[0] : ifc.M_Addr);
      check("dm_wd",    ifc.DM_WD,         gnt ? ifc.X_WD : ifc.M_WD);
      check("dm_op",    32'(ifc.DM_Op),    gnt ? 32'(WOP) : 32'(ifc.M_Op));
      check("m_rd",     ifc.M_RD,          mem_val(ifc.DM_A));
      @(posedge Clk);
      e_done = 1'b0;
      e_rv   = 1'b0;
      if (!Rst) begin
         model_reset();
      end else if (gnt) begin
         a      = beat_q.pop_front();
         starve = 0;
         if (!m_wr) begin
            e_rv = 1'b1;
            e_rd = mem_val(a);
         end
         if (beat_q.size() == 0) e_done = 1'b1;
      end else if (busy) begin
         starve++;
      end else if (xreq) begin
         for (int i = 0; i <= int'(xlen); i++)
            beat_q.push_back((xaddr & 32'hFFFF_FFFC) + 32'(4 * i));
         m_wr   = xwr;
         starve = 0;
      end
      #1;
   endtask

   task automatic idle_cycles(input int n, input logic req);
      for (int i = 0; i < n; i++) cyc(req, 1'b0, 1'b0, 1'b0, 32'd0, 3'd0);
   endtask

   initial begin
      logic [31:0] maddr;
      model_reset();
      Rst = 1'b0;
      // Reset state
      idle_cycles(2, 1'b0);
      @(negedge Clk);
      Rst = 1'b1;
      @(posedge Clk);
      #1;

      // Uncontested 4-beat write from an unaligned base
      obs_beats = 0;
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103, 3'd3);
      idle_cycles(5, 1'b0);
      check("t2_beats", 32'(obs_beats), 32'd4);

      // Starvation: 1-beat read with the pipeline always requesting
      obs_stalls = 0;
      obs_beats  = 0;
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 3'd0);
      idle_cycles(6, 1'b1);
      check("t3_stalls", 32'(obs_stalls), 32'd1);
      check("t3_beats",  32'(obs_beats),  32'd1);

      // Interleave: 2-beat read, M_Req 1,0,1,0
      obs_stalls = 0;
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 3'd1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 3'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 3'd0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 3'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 3'd0);
      idle_cycles(2, 1'b0);
      check("t4_stalls", 32'(obs_stalls), 32'd0);

      // Ignored request in BURST; new request taken in the X_Done cycle
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 3'd3);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0900, 3'd7);
      idle_cycles(3, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0500, 3'd0);
      check("t5_busy_after_done", 32'(ifc.X_Busy), 32'd1);
      idle_cycles(3, 1'b0);

      // Address wrap
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 3'd1);
      idle_cycles(3, 1'b0);

      // Reset in the middle of a write burst
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0800, 3'd7);
      idle_cycles(2, 1'b0);
      maddr = 32'h1234_5678;
      ifc.M_Req  = 1'b1;
      ifc.M_Wr   = 1'b1;
      ifc.M_Addr = maddr;
      #2;
      Rst = 1'b0;
      #1;
      check("rst_dm_wr",    32'(ifc.DM_Wr),    32'd1);
      check("rst_dm_a",     ifc.DM_A,          maddr);
      check("rst_x_busy",   32'(ifc.X_Busy),   32'd0);
      check("rst_x_done",   32'(ifc.X_Done),   32'd0);
      check("rst_x_rvalid", 32'(ifc.X_RValid), 32'd0);
      check("rst_m_stall",  32'(ifc.M_Stall),  32'd0);
      model_reset();
      @(posedge Clk);
      #1;
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 3'd0);
      @(negedge Clk);
      Rst = 1'b1;
      @(posedge Clk);
      #1;
      idle_cycles(3, 1'b0);

      // Randomized traffic with varying pipeline load
      for (int seg = 0; seg < 6; seg++) begin
         int pct;
         pct = (seg % 3 == 0) ? 95 : (seg % 3 == 1) ? 50 : 10;
         for (int i = 0; i < 120; i++) begin
            cyc(($urandom_range(0, 99) < pct), 1'($urandom), ($urandom_range(0, 3) == 0),
                1'($urandom), $urandom, 3'($urandom_range(0, 7)));
         end
      end
      idle_cycles(60, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
